mem_access_stage: RTL and testbench
===================================

# mem_access_stage

Memory-access stage of the 5-stage RISC-V pipeline. It sits between the EX/MEM pipeline register and the MEM/WB register (Stage4), and runs loads and stores against a data memory through a req/ack bus that can take several cycles. It stalls the upstream pipeline while a transaction is outstanding, and hands Stage4 an aligned, sign- or zero-extended read value plus a gated register-write enable.

## Interface
- `TIMEOUT_CYCLES`, default 16: maximum cycles in BUSY without `mem_ack` before the access is aborted; must be ≥1.
- `clk` in 1: clock; all state changes on the rising edge.
- `reset` in 1: synchronous reset, active-low, sampled on the rising edge of `clk`.
- `AluResultM` in 32: effective byte address.
- `WriteDataM` in 32: store data, taken from the low bits.
- `MemWriteM` in 1: store instruction in M.
- `ResultSrcM` in 2: 2'b01 marks a load; other values mean no read.
- `RegWriteM` in 1: register-write enable from EX/MEM.
- `funct3M` in 3: access size and sign (000 b, 001 h, 010 w, 100 bu, 101 hu).
- `RD` out 32: load result to Stage4.
- `RegWriteMO` out 1: gated register-write enable to Stage4.
- `StallM` out 1: holds PC, IF/ID, ID/EX and EX/MEM.
- `misaligned_err` out 1: single-cycle flag for a misaligned or illegal access.
- `bus_err` out 1: single-cycle flag for a timeout abort.
- `mem_req` out 1: bus request, registered.
- `mem_we` out 1: write strobe, registered.
- `mem_addr` out 32: word address, {addr[31:2],2'b00}, registered.
- `mem_wdata` out 32: lane-replicated store data, registered.
- `mem_be` out 4: byte enables, registered.
- `mem_ack` in 1: transaction complete, sampled at the edge.
- `mem_rdata` in 32: read word, valid in the same cycle as `mem_ack`.

## Operation
- Memory op: `MemWriteM` is high, or `ResultSrcM`==2'b01.
- Non-memory op: RD=0, RegWriteMO=RegWriteM, StallM=0, single cycle.
- Illegal access, any of:
  - half access with addr[0]=1;
  - word access with addr[1:0]≠0;
  - load funct3 ∉ {000,001,010,100,101};
  - store funct3 ∉ {000,001,010}.
- Illegal access response, in the same cycle:
  - misaligned_err=1, no bus request, StallM=0;
  - RegWriteMO=0, RD=0.
- FSM states are IDLE and BUSY.
- IDLE with a legal memory op:
  - StallM=1, RegWriteMO=0 (bubble into Stage4).
  - At the edge: mem_req←1; mem_we←MemWriteM; mem_addr, mem_be and mem_wdata loaded.
  - Byte offset, funct3 and load flag latched internally; cycle counter cleared; state→BUSY.
- Byte enables and store data, little-endian, off = addr[1:0]:
  - sb: be=4'b0001<<off, wdata={4{byte}}.
  - sh: be=4'b0011<<off, wdata={2{half}}.
  - sw: be=4'b1111, wdata=WriteDataM.
  - Loads: be computed the same way, mem_we=0.
- BUSY without ack: StallM=1, RegWriteMO=0, counter increments; bus outputs held stable.
- BUSY with mem_ack=1, in that cycle:
  - StallM=0, RegWriteMO=RegWriteM.
  - RD = latched-size extract of mem_rdata at the latched offset: lb/lh sign-extend, lbu/lhu zero-extend, lw whole word. RD=0 for stores.
  - At the edge: mem_req←0, state→IDLE.
- BUSY timeout, counter reaching TIMEOUT_CYCLES-1 with no ack, in that cycle:
  - bus_err=1, StallM=0, RegWriteMO=0, RD=0.
  - At the edge: mem_req←0, state→IDLE.
- An ack that arrives in the same cycle as the timeout wins; no bus_err.
- An ack while in IDLE is ignored.

## Timing
- Reset (reset=0 at an edge):
  - state=IDLE; mem_req, mem_we, mem_be, mem_addr, mem_wdata and the counter = 0.
  - Combinational outputs follow from IDLE with the current inputs.
  - Reset in BUSY drops mem_req at that edge; the transaction is abandoned and no error is flagged.
- Latency:
  - Non-memory op: 1 cycle.
  - Memory op: 1 launch cycle + k BUSY cycles, with ack in BUSY cycle k≥1. Minimum is 2 cycles.
  - Timeout: exactly 1 + TIMEOUT_CYCLES cycles.
- mem_req is never asserted in two consecutive transactions without at least one cycle low in between.
- StallM, RD, RegWriteMO, misaligned_err and bus_err are combinational from the state and the current inputs. Stage4 captures them at the same edge.
- mem_* outputs change only at the launch edge and the completion edge.

## Test plan
- ALU op, RegWriteM=1, AluResultM=0x10 → RD=0, RegWriteMO=1, StallM=0, mem_req never rises.
- lw at 0x100, ack in the 3rd BUSY cycle with rdata=0xDEADBEEF:
  - mem_addr=0x100, be=4'hF.
  - StallM high 3 cycles.
  - In the ack cycle: RD=0xDEADBEEF, RegWriteMO=1.
- lb/lbu at 0x103, rdata=0x80FF_0000 → lb RD=0xFFFFFF80; lbu RD=0x00000080; be=4'b1000.
- sh 0x1234ABCD at 0x202, ack in the 1st BUSY cycle → mem_we=1, mem_addr=0x200, be=4'b1100, wdata=0xABCDABCD, RegWriteMO=0.
- lw at 0x101 → misaligned_err=1 for 1 cycle, mem_req stays 0, StallM=0, RegWriteMO=0.
- TIMEOUT_CYCLES=4, lw with no ack:
  - bus_err pulses in the 4th BUSY cycle; mem_req falls at that edge.
  - A second run pulls reset low in BUSY cycle 2 → mem_req=0 and state=IDLE next cycle, bus_err never asserted.

Source files
------------

// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: launches loads/stores on a req/ack data bus,
// stalls upstream while a transaction is outstanding and aborts after TIMEOUT_CYCLES.
module mem_access_stage #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] AluResultM,
    input  logic [31:0] WriteDataM,
    input  logic        MemWriteM,
    input  logic [1:0]  ResultSrcM,
    input  logic        RegWriteM,
    input  logic [2:0]  funct3M,
    output logic [31:0] RD,
    output logic        RegWriteMO,
    output logic        StallM,
    output logic        misaligned_err,
    output logic        bus_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t           state, state_next;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       lat_off;
    logic [2:0]       lat_funct3;
    logic             lat_load;

    logic        is_load, is_mem, size_ok, align_ok, illegal;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        launch, finish, timeout;
    logic [15:0] lane;
    logic [31:0] load_val;

    // Access decode for the instruction currently in M.
    always_comb begin
        // NOTE: every signal gets a value before any branch, so no path leaves it
        // unassigned and no latch is inferred.
        is_load  = (ResultSrcM == 2'b01);
        is_mem   = MemWriteM | is_load;
        size_ok  = 1'b0;
        align_ok = 1'b1;
        be       = 4'b1111;
        wdata    = WriteDataM;

        if (MemWriteM)
            size_ok = !funct3M[2] && (funct3M[1:0] != 2'b11);
        else
            size_ok = (funct3M[1:0] != 2'b11) && (funct3M != 3'b110);

        case (funct3M[1:0])
            2'b00: begin
                be    = 4'b0001 << AluResultM[1:0];
                wdata = {4{WriteDataM[7:0]}};
            end
            2'b01: begin
                align_ok = !AluResultM[0];
                be       = 4'b0011 << AluResultM[1:0];
                wdata    = {2{WriteDataM[15:0]}};
            end
            default: begin
                align_ok = (AluResultM[1:0] == 2'b00);
            end
        endcase

        illegal = is_mem && !(size_ok && align_ok);
    end

    // Load data alignment and extension using the size/offset latched at launch.
    always_comb begin
        lane = 16'(mem_rdata >> {lat_off, 3'b000});
        case (lat_funct3)
            3'b000:  load_val = {{24{lane[7]}}, lane[7:0]};
            3'b001:  load_val = {{16{lane[15]}}, lane[15:0]};
            3'b100:  load_val = {24'b0, lane[7:0]};
            3'b101:  load_val = {16'b0, lane[15:0]};
            default: load_val = mem_rdata;
        endcase
    end

    assign timeout = (cnt == CNT_LAST);

    always_comb begin
        state_next     = state;
        StallM         = 1'b0;
        RegWriteMO     = 1'b0;
        RD             = '0;
        misaligned_err = 1'b0;
        bus_err        = 1'b0;
        launch         = 1'b0;
        finish         = 1'b0;

        case (state)
            IDLE: begin
                if (!is_mem) begin
                    RegWriteMO = RegWriteM;
                end else if (illegal) begin
                    misaligned_err = 1'b1;
                end else begin
                    StallM     = 1'b1;
                    launch     = 1'b1;
                    state_next = BUSY;
                end
            end
            BUSY: begin
                // An ack in the timeout cycle still completes the access normally.
                if (mem_ack) begin
                    RegWriteMO = RegWriteM;
                    RD         = lat_load ? load_val : '0;
                    finish     = 1'b1;
                    state_next = IDLE;
                end else if (timeout) begin
                    bus_err    = 1'b1;
                    finish     = 1'b1;
                    state_next = IDLE;
                end else begin
                    StallM = 1'b1;
                end
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (!reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_be     <= '0;
            cnt        <= '0;
            lat_off    <= '0;
            lat_funct3 <= '0;
            lat_load   <= 1'b0;
        end else if (launch) begin
            mem_req    <= 1'b1;
            mem_we     <= MemWriteM;
            mem_addr   <= {AluResultM[31:2], 2'b00};
            mem_wdata  <= wdata;
            mem_be     <= be;
            cnt        <= '0;
            lat_off    <= AluResultM[1:0];
            lat_funct3 <= funct3M;
            lat_load   <= is_load & ~MemWriteM;
        end else if (finish) begin
            mem_req <= 1'b0;
        end else if (state == BUSY) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: directed scenarios followed by random
// traffic, all compared every cycle against a transaction-level reference model.
module tb_mem_access_stage;

    localparam int T = 4;

    logic        clk;
    logic        reset;
    logic [31:0] AluResultM;
    logic [31:0] WriteDataM;
    logic        MemWriteM;
    logic [1:0]  ResultSrcM;
    logic        RegWriteM;
    logic [2:0]  funct3M;
    logic [31:0] RD;
    logic        RegWriteMO;
    logic        StallM;
    logic        misaligned_err;
    logic        bus_err;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    mem_access_stage #(.TIMEOUT_CYCLES(T)) dut (
        .clk           (clk),
        .reset         (reset),
        .AluResultM    (AluResultM),
        .WriteDataM    (WriteDataM),
        .MemWriteM     (MemWriteM),
        .ResultSrcM    (ResultSrcM),
        .RegWriteM     (RegWriteM),
        .funct3M       (funct3M),
        .RD            (RD),
        .RegWriteMO    (RegWriteMO),
        .StallM        (StallM),
        .misaligned_err(misaligned_err),
        .bus_err       (bus_err),
        .mem_req       (mem_req),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_be        (mem_be),
        .mem_ack       (mem_ack),
        .mem_rdata     (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: one outstanding transaction and the bus word it put out.
    bit          m_busy;
    int          m_k;
    logic [1:0]  m_off;
    logic [2:0]  m_f3;
    bit          m_store;
    logic        m_req;
    logic        m_we;
    logic [31:0] m_maddr;
    logic [31:0] m_wdata;
    logic [3:0]  m_be;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit legal_access(bit store, logic [2:0] f3, logic [31:0] addr);
        int unsigned bytes = 1 << f3[1:0];
        if (store) begin
            if (!(f3 inside {3'd0, 3'd1, 3'd2})) return 1'b0;
        end else begin
            if (!(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) return 1'b0;
        end
        return (addr % bytes) == 0;
    endfunction

    function automatic logic [3:0] byte_enables(logic [2:0] f3, logic [31:0] addr);
        int unsigned bytes = 1 << f3[1:0];
        int unsigned mask  = ((1 << bytes) - 1) << (addr % 4);
        return 4'(mask);
    endfunction

    function automatic logic [31:0] store_word(logic [2:0] f3, logic [31:0] data);
        case (f3[1:0])
            2'b00:   return (data & 32'hFF) * 32'h0101_0101;
            2'b01:   return (data & 32'hFFFF) * 32'h0001_0001;
            default: return data;
        endcase
    endfunction

    function automatic logic [31:0] load_value(logic [2:0] f3, logic [1:0] off, logic [31:0] w);
        int unsigned b = (w >> (8 * off)) & 32'hFF;
        int unsigned h = (w >> (8 * off)) & 32'hFFFF;
        case (f3)
            3'd0:    return (b >= 128) ? b + 32'hFFFF_FF00 : b;
            3'd1:    return (h >= 32768) ? h + 32'hFFFF_0000 : h;
            3'd4:    return b;
            3'd5:    return h;
            default: return w;
        endcase
    endfunction

    task automatic model_reset();
        m_busy  = 1'b0;
        m_k     = 0;
        m_req   = 1'b0;
        m_we    = 1'b0;
        m_maddr = '0;
        m_wdata = '0;
        m_be    = '0;
    endtask

    // Compare every output against the model, mid low phase.
    task automatic settle_check();
        bit          ld;
        bit          st;
        logic [31:0] e_rd;
        logic        e_rw, e_stall, e_mis, e_berr;
        #1;
        ld      = (ResultSrcM == 2'b01);
        st      = MemWriteM;
        e_rd    = '0;
        e_rw    = 1'b0;
        e_stall = 1'b0;
        e_mis   = 1'b0;
        e_berr  = 1'b0;
        if (!m_busy) begin
            if (!(ld || st))                              e_rw = RegWriteM;
            else if (!legal_access(st, funct3M, AluResultM)) e_mis = 1'b1;
            else                                          e_stall = 1'b1;
        end else if (mem_ack) begin
            e_rw = RegWriteM;
            e_rd = m_store ? 32'h0 : load_value(m_f3, m_off, mem_rdata);
        end else if (m_k == T) begin
            e_berr = 1'b1;
        end else begin
            e_stall = 1'b1;
        end
        check("RD", RD, e_rd);
        check("RegWriteMO", 32'(RegWriteMO), 32'(e_rw));
        check("StallM", 32'(StallM), 32'(e_stall));
        check("misaligned_err", 32'(misaligned_err), 32'(e_mis));
        check("bus_err", 32'(bus_err), 32'(e_berr));
        check("mem_req", 32'(mem_req), 32'(m_req));
        check("mem_we", 32'(mem_we), 32'(m_we));
        check("mem_addr", mem_addr, m_maddr);
        check("mem_be", 32'(mem_be), 32'(m_be));
        if (m_we) check("mem_wdata", mem_wdata, m_wdata);
    endtask

    // Advance the model across one rising edge, then return at the falling edge.
    task automatic edge_step();
        bit ld;
        bit st;
        @(posedge clk);
        ld = (ResultSrcM == 2'b01);
        st = MemWriteM;
        if (!reset) begin
            model_reset();
        end else if (!m_busy) begin
            if ((ld || st) && legal_access(st, funct3M, AluResultM)) begin
                m_busy  = 1'b1;
                m_k     = 1;
                m_off   = AluResultM[1:0];
                m_f3    = funct3M;
                m_store = st;
                m_req   = 1'b1;
                m_we    = st;
                m_maddr = AluResultM & 32'hFFFF_FFFC;
                m_be    = byte_enables(funct3M, AluResultM);
                m_wdata = store_word(funct3M, WriteDataM);
            end
        end else if (mem_ack || m_k == T) begin
            m_busy = 1'b0;
            m_req  = 1'b0;
        end else begin
            m_k++;
        end
        @(negedge clk);
    endtask

    task automatic tick();
        settle_check();
        edge_step();
    endtask

    task automatic set_idle();
        AluResultM = '0;
        WriteDataM = '0;
        MemWriteM  = 1'b0;
        ResultSrcM = 2'b00;
        RegWriteM  = 1'b0;
        funct3M    = 3'b000;
        mem_ack    = 1'b0;
        mem_rdata  = '0;
    endtask

    task automatic drive_load(input logic [2:0] f3, input logic [31:0] addr);
        set_idle();
        ResultSrcM = 2'b01;
        RegWriteM  = 1'b1;
        funct3M    = f3;
        AluResultM = addr;
    endtask

    initial begin
        int stalls;
        int kind;

        set_idle();
        reset = 1'b0;
        @(posedge clk);
        model_reset();
        @(negedge clk);
        tick();
        reset = 1'b1;

        // ALU op with a stray ack in IDLE: passes straight through.
        set_idle();
        RegWriteM  = 1'b1;
        AluResultM = 32'h10;
        mem_ack    = 1'b1;
        mem_rdata  = 32'h1234_5678;
        settle_check();
        check("alu_RD", RD, 32'h0);
        check("alu_RegWriteMO", 32'(RegWriteMO), 32'd1);
        edge_step();
        tick();
        check("alu_no_req", 32'(mem_req), 32'd0);

        // lw 0x100, ack in the 3rd BUSY cycle.
        drive_load(3'b010, 32'h100);
        stalls = 0;
        settle_check();
        stalls += int'(StallM);
        edge_step();
        check("lw_addr", mem_addr, 32'h100);
        check("lw_be", 32'(mem_be), 32'hF);
        repeat (2) begin
            settle_check();
            stalls += int'(StallM);
            edge_step();
        end
        mem_ack   = 1'b1;
        mem_rdata = 32'hDEAD_BEEF;
        settle_check();
        stalls += int'(StallM);
        check("lw_RD", RD, 32'hDEAD_BEEF);
        check("lw_RegWriteMO", 32'(RegWriteMO), 32'd1);
        check("lw_stall_cycles", 32'(stalls), 32'd3);
        edge_step();
        set_idle();
        tick();

        // lb / lbu at 0x103, ack in the 1st BUSY cycle.
        for (int i = 0; i < 2; i++) begin
            drive_load((i == 0) ? 3'b000 : 3'b100, 32'h103);
            tick();
            check("lb_be", 32'(mem_be), 32'h8);
            mem_ack   = 1'b1;
            mem_rdata = 32'h80FF_0000;
            settle_check();
            check("lb_RD", RD, (i == 0) ? 32'hFFFF_FF80 : 32'h0000_0080);
            edge_step();
            set_idle();
            tick();
        end

        // sh 0x1234ABCD at 0x202.
        set_idle();
        MemWriteM  = 1'b1;
        funct3M    = 3'b001;
        AluResultM = 32'h202;
        WriteDataM = 32'h1234_ABCD;
        tick();
        check("sh_we", 32'(mem_we), 32'd1);
        check("sh_addr", mem_addr, 32'h200);
        check("sh_be", 32'(mem_be), 32'hC);
        check("sh_wdata", mem_wdata, 32'hABCD_ABCD);
        mem_ack = 1'b1;
        settle_check();
        check("sh_RegWriteMO", 32'(RegWriteMO), 32'd0);
        edge_step();

        // Misaligned lw at 0x101.
        drive_load(3'b010, 32'h101);
        settle_check();
        check("mis_flag", 32'(misaligned_err), 32'd1);
        check("mis_stall", 32'(StallM), 32'd0);
        edge_step();
        set_idle();
        settle_check();
        check("mis_no_req", 32'(mem_req), 32'd0);
        check("mis_one_cycle", 32'(misaligned_err), 32'd0);
        edge_step();

        // Timeout: lw with no ack.
        drive_load(3'b010, 32'h100);
        repeat (4) tick();
        settle_check();
        check("to_bus_err", 32'(bus_err), 32'd1);
        check("to_stall", 32'(StallM), 32'd0);
        edge_step();
        check("to_req_drop", 32'(mem_req), 32'd0);
        set_idle();
        tick();

        // Reset pulled low in BUSY cycle 2.
        drive_load(3'b010, 32'h100);
        tick();
        tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        set_idle();
        settle_check();
        check("rst_req", 32'(mem_req), 32'd0);
        check("rst_idle", 32'(StallM), 32'd0);
        edge_step();

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            set_idle();
            kind = int'($urandom_range(0, 3));
            MemWriteM  = (kind == 2);
            ResultSrcM = (kind == 1 || kind == 3) ? 2'b01 : (($urandom_range(0, 1) == 0) ? 2'b10 : 2'b11);
            if (kind == 0 && $urandom_range(0, 2) == 0) ResultSrcM = 2'b00;
            RegWriteM  = 1'($urandom_range(0, 1));
            funct3M    = 3'($urandom_range(0, 7));
            AluResultM = $urandom;
            if ($urandom_range(0, 1) == 0) AluResultM[1:0] = 2'b00;
            WriteDataM = $urandom;
            mem_ack    = ($urandom_range(0, 2) == 0);
            mem_rdata  = $urandom;
            reset      = ($urandom_range(0, 49) != 0);
            tick();
        end
        reset = 1'b1;
        set_idle();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
